// File: rtl/arb4_sched.sv
// 4-requester arbiter with registered one-hot grant, hold-until-release and hold timeout.
// Optional ARB4_ROUND_ROBIN_EN replaces fixed priority (3 highest) with a round-robin search.
module arb4_sched #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = $clog2(MAX_HOLD)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_vld
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       gnt_nxt;
  logic [1:0]       idx_nxt;
  logic [3:0]       masked;
  logic             owner_req;
  logic             hold_max;
  logic             win_vld;
  logic [1:0]       win_idx;
  logic             issue;

`ifdef ARB4_ROUND_ROBIN_EN
  logic [1:0] ptr;

  // Later search positions are overwritten by earlier ones, so the first hit after last wins.
  function automatic logic [2:0] arb_pick(input logic [3:0] m, input logic [1:0] last);
    logic [2:0] r;
    logic [1:0] i;
    r = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      i = last + 2'(k);
      if (m[i]) r = {1'b1, i};
    end
    return r;
  endfunction
`else
  function automatic logic [2:0] arb_pick(input logic [3:0] m);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction
`endif

  // gnt is zero in IDLE, so masking with it covers both fresh and handover arbitration.
  assign masked    = req & ~gnt;
  assign owner_req = |(req & gnt);
  assign hold_max  = (cnt == CNT_MAX);

  always_comb begin
`ifdef ARB4_ROUND_ROBIN_EN
    {win_vld, win_idx} = arb_pick(masked, ptr);
`else
    {win_vld, win_idx} = arb_pick(masked);
`endif
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    idx_nxt   = gnt_idx;
    cnt_nxt   = cnt;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (win_vld) issue = 1'b1;
      end
      GRANT: begin
        if (!owner_req) begin
          if (win_vld) begin
            issue = 1'b1;
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = 4'b0000;
            idx_nxt   = 2'b00;
            cnt_nxt   = '0;
          end
        end else if (hold_max && win_vld) begin
          issue = 1'b1;
        end else if (!hold_max) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (issue) begin
      state_nxt = GRANT;
      gnt_nxt   = 4'b0001 << win_idx;
      idx_nxt   = win_idx;
      cnt_nxt   = '0;
    end
  end

  // Registered grant stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      gnt     <= 4'b0000;
      gnt_idx <= 2'b00;
      gnt_vld <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      gnt     <= gnt_nxt;
      gnt_idx <= idx_nxt;
      gnt_vld <= |gnt_nxt;
    end
  end

`ifdef ARB4_ROUND_ROBIN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        ptr <= 2'b00;
    else if (issue) ptr <= win_idx;
  end
`endif

endmodule

// File: tb/tb_arb4_sched.sv
// Bench for arb4_sched: directed request vectors, a cycle-level reference model compared
// every cycle, plus literal expectations for the key scenarios.
module tb_arb4_sched;

  localparam int MAX_HOLD = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_vld;

  int n_vec = 0;
  int n_bad = 0;

  arb4_sched #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_vld(gnt_vld)
  );

  always #5 clk = ~clk;

  // Reference model: owner (-1 = idle), cycles held since grant (unbounded), last granted index.
  int         m_owner = -1;
  int         m_held  = 0;
  int         m_last  = 0;
  logic [3:0] m_others;
  int         m_w;

  function automatic int pick(input logic [3:0] m, input int last);
`ifdef ARB4_ROUND_ROBIN_EN
    for (int k = 1; k <= 4; k++) if (m[(last + k) % 4]) return (last + k) % 4;
`else
    for (int i = 3; i >= 0; i--) if (m[i]) return i;
`endif
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = -1; m_held = 0; m_last = 0;
    end else begin
      m_others = req;
      if (m_owner >= 0) m_others[m_owner] = 1'b0;
      m_w = pick(m_others, m_last);
      if (m_owner < 0 || !req[m_owner]) begin
        if (m_w >= 0) begin m_owner = m_w; m_held = 0; m_last = m_w; end
        else m_owner = -1;
      end else if (m_held >= MAX_HOLD - 1 && m_w >= 0) begin
        m_owner = m_w; m_held = 0; m_last = m_w;
      end else begin
        m_held++;
      end
    end
  end

  logic [3:0] e_gnt;
  logic [1:0] e_idx;
  always @(negedge clk) begin
    e_gnt = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    e_idx = (m_owner >= 0) ? 2'(m_owner) : 2'b00;
    n_vec++;
    if (gnt !== e_gnt || gnt_idx !== e_idx || gnt_vld !== (e_gnt != 0)) begin
      n_bad++;
      $display("FAIL model t=%0t: gnt=%b idx=%0d vld=%b, expected gnt=%b idx=%0d vld=%b",
               $time, gnt, gnt_idx, gnt_vld, e_gnt, e_idx, (e_gnt != 0));
    end
  end

  task automatic chk(input string name, input logic [3:0] eg, input logic [1:0] ei);
    n_vec++;
    if (gnt !== eg || gnt_idx !== ei || gnt_vld !== (eg != 4'b0000)) begin
      n_bad++;
      $display("FAIL %s: gnt=%b idx=%0d vld=%b, expected gnt=%b idx=%0d vld=%b",
               name, gnt, gnt_idx, gnt_vld, eg, ei, (eg != 4'b0000));
    end
  endtask

  task automatic step(input logic [3:0] r);
    req = r;
    @(posedge clk);
    #1;
  endtask

`ifdef ARB4_ROUND_ROBIN_EN
  int exp_rr [5] = '{1, 2, 3, 0, 1};
`endif

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", 4'b0000, 2'd0);
    rst = 1'b0;

    // Tie from idle, then owner releases
    step(4'b1111);
`ifdef ARB4_ROUND_ROBIN_EN
    chk("tie", 4'b0010, 2'd1);
    step(4'b0111);
    chk("tie_release", 4'b0010, 2'd1);
`else
    chk("tie", 4'b1000, 2'd3);
    step(4'b0111);
    chk("tie_release", 4'b0100, 2'd2);
`endif
    step(4'b0000);
    chk("idle", 4'b0000, 2'd0);

    // Single requester, never preempted
    repeat (40) step(4'b0001);
    chk("single_40", 4'b0001, 2'd0);
    step(4'b0000);
    chk("single_drop", 4'b0000, 2'd0);

    // Release and arrival on the same edge
    step(4'b0010);
    chk("own1", 4'b0010, 2'd1);
    step(4'b0001);
    chk("collision", 4'b0001, 2'd0);
    step(4'b0000);

    // Hold timeout alternation
    for (int i = 0; i < 48; i++) begin
      step(4'b1001);
      if (i == 0)  chk("timeout_first", 4'b1000, 2'd3);
      if (i == 15) chk("timeout_hold15", 4'b1000, 2'd3);
      if (i == 16) chk("timeout_swap", 4'b0001, 2'd0);
      if (i == 31) chk("timeout_hold31", 4'b0001, 2'd0);
      if (i == 32) chk("timeout_back", 4'b1000, 2'd3);
    end

    // Async reset mid-grant
    step(4'b0100);
    chk("handover_to2", 4'b0100, 2'd2);
    #3 rst = 1'b1;
    #1 chk("rst_async", 4'b0000, 2'd0);
    @(posedge clk);
    #1 chk("rst_held", 4'b0000, 2'd0);
    rst = 1'b0;
    step(4'b0100);
    chk("after_rst", 4'b0100, 2'd2);

    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
`ifdef ARB4_ROUND_ROBIN_EN
    step(4'b1111);
    chk("rr_0", 4'b0001 << exp_rr[0], 2'(exp_rr[0]));
    for (int k = 1; k < 5; k++) begin
      step(4'b1111 & ~(4'b0001 << exp_rr[k-1]));
      chk("rr_order", 4'b0001 << exp_rr[k], 2'(exp_rr[k]));
    end
`else
    for (int k = 0; k < 5; k++) begin
      step(4'b1111);
      chk("fixed_order", 4'b1000, 2'd3);
    end
`endif
    step(4'b0000);
    chk("final_idle", 4'b0000, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/arb4_sched.md
Name: arb4_sched

Overview:
- Clocked 4-requester arbiter that shares one resource (bus or datapath slot) between requesters 0..3.
- Uses the team's 4-input priority-encoding rule: index 3 highest, index 0 lowest.
- Registers the winner and holds the grant until the owner releases or a hold timeout forces handover.
- Outputs a one-hot grant plus a 2-bit encoded index for driving downstream muxes.

Parameters:
- MAX_HOLD, 16, maximum consecutive cycles one owner keeps the grant while others wait; legal range 2..256.
- CNT_W, $clog2(MAX_HOLD), width of the internal hold counter; derived, do not override.

Ports:
- clk      input   1  rising-edge clock
- rst      input   1  asynchronous, active-high reset
- req      input   4  request per requester; req[i] high = requester i wants the resource
- gnt      output  4  registered one-hot grant; all zero when idle
- gnt_idx  output  2  binary index of the current owner (3 -> 2'b11, 0 -> 2'b00); 2'b00 when idle
- gnt_vld  output  1  high whenever gnt is non-zero

Interface: one clock; reset is asynchronous and active-high.

Behaviour:
- Reset (async assert, any cycle): gnt=4'b0000, gnt_idx=2'b00, gnt_vld=0, state=IDLE, hold counter=0, RR pointer=0. Takes effect immediately, including mid-grant. After deassertion, the first arbitration happens on the next rising edge.
- All outputs are registered. There are no combinational paths from req to outputs.
- State IDLE:
  - If req!=0, the winner is selected per the priority rule.
  - On the next edge: gnt=onehot(winner), gnt_idx=winner, gnt_vld=1, counter=0, go to GRANT.
  - Latency from req to gnt is 1 cycle.
- State GRANT, evaluated each edge, owner = gnt_idx:
  - Release: req[owner]=0.
    - Arbitrate among req with the owner bit masked.
    - If a winner exists, hand over on this edge with no idle cycle; counter=0.
    - Otherwise go to IDLE with outputs cleared.
  - Timeout: req[owner]=1, counter==MAX_HOLD-1, and (req & ~onehot(owner))!=0.
    - Forced handover to the masked-arbitration winner; counter=0.
    - The preempted owner may re-win later under normal rules.
  - Otherwise keep the owner.
    - Counter increments, saturating at MAX_HOLD-1.
    - The counter does not advance past saturation while no one else waits.
- Fixed priority (default): winner = highest set index of the masked request vector.
- Simultaneous events:
  - Release and timeout in the same cycle: treated as a release.
  - A request arriving in the same cycle as a release participates in that arbitration.
- A requester dropping req while not granted has no effect.
- gnt is always one-hot or zero. gnt_vld equals |gnt.

Optional Feature:
- Macro ARB4_ROUND_ROBIN_EN.
- Defined:
  - Winner = first set bit of the masked request vector, searching upward from (last_owner+1) mod 4 and wrapping 3->0.
  - The RR pointer updates on every grant issue.
  - Reset pointer = 0, so the first search starts at index 1.
- Undefined: fixed priority as above; no pointer register is synthesised.

Test Plan:
- Reset mid-grant: owner 2 held, assert rst between edges -> gnt=0000, gnt_vld=0 immediately; after release, req=0100 -> gnt=0100 one edge later.
- Fixed-priority tie: req=1111 from IDLE -> next edge gnt=1000, gnt_idx=11. Drop req[3] -> next edge gnt=0100, gnt_idx=10, no idle cycle.
- Single requester, no contention: req=0001 held 40 cycles -> gnt=0001 throughout, never preempted. Drop req -> next edge gnt=0000, gnt_vld=0.
- Timeout (MAX_HOLD=16): req=1001 constant -> gnt=1000 for 16 cycles, then gnt=0001 for 16 cycles, then back to 1000.
- Release/arrival collision: owner 1 drops req[1] on the same edge req[0] rises -> next edge gnt=0001, gnt_idx=00.
- ARB4_ROUND_ROBIN_EN defined, req=1111 held, owners release after 1 cycle each -> grant order 1,2,3,0,1; without the macro the order is 3,3,3...
